// File: rtl/adc_readout.sv
// Parallel serial readout of 32 ADC lines into a one-frame bank, streamed as channel-tagged words.
// Defining ADC_READOUT_TEST_PATTERN_EN adds TEST_PAT, which replaces the bank with {frame_counter, channel}.
module adc_readout #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned SAMPLE_BITS = 16,
   parameter int unsigned CONV_WAIT   = 8
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   START,
   input  logic                   CONTINUOUS,
   input  logic                   CLR_OVR,
`ifdef ADC_READOUT_TEST_PATTERN_EN
   input  logic                   TEST_PAT,
`endif
   output logic [1:0]             ADC_CLK_OUT,
   output logic [3:0]             ADC_CS_OUT,
   input  logic [31:0]            ADC_DATA_IN,
   output logic                   DOUT_VALID,
   input  logic                   DOUT_READY,
   output logic [4:0]             DOUT_CH,
   output logic [SAMPLE_BITS-1:0] DOUT_DATA,
   output logic                   BUSY,
   output logic                   OVERRUN
);

   localparam int unsigned CNT_MAX = (CLK_DIV > CONV_WAIT) ? CLK_DIV : CONV_WAIT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam int unsigned BIT_W   = $clog2(SAMPLE_BITS);
   localparam int unsigned FC_W    = 16;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CONV_WAIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP} state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   half_q, half_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic                   sclk_q, sclk_d;
   logic                   cs_q, cs_d;
   logic                   busy_q, busy_d;
   logic                   capture_c, frame_done_c;

   logic [SAMPLE_BITS-1:0] sr_q [32];
   logic [SAMPLE_BITS-1:0] sr_d [32];
   logic [SAMPLE_BITS-1:0] bank_q [32];
   logic [SAMPLE_BITS-1:0] bank_d [32];
   logic [SAMPLE_BITS-1:0] load_word_c [32];
   logic                   valid_q, valid_d;
   logic [4:0]             ch_q, ch_d;
   logic [4:0]             ch_nxt_c;
   logic [SAMPLE_BITS-1:0] data_q, data_d;
   logic                   ovr_q, ovr_d;
   logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;
   logic                   accept_c, bank_free_c;

   // Frame sequencer; outputs are registered from the next state so pins change with the state.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      half_d       = half_q;
      bit_d        = bit_q;
      capture_c    = 1'b0;
      frame_done_c = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_CS_SETUP;
               cnt_d   = '0;
            end
         end
         S_CS_SETUP: begin
            if (cnt_q == DIV_LAST) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               half_d  = 1'b0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_SHIFT: begin
            if (cnt_q != DIV_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (!half_q) begin
               capture_c = 1'b1;
               half_d    = 1'b1;
               cnt_d     = '0;
            end else if (bit_q == BIT_LAST) begin
               state_d = S_CS_HOLD;
               cnt_d   = '0;
            end else begin
               bit_d  = bit_q + BIT_W'(1);
               half_d = 1'b0;
               cnt_d  = '0;
            end
         end
         S_CS_HOLD: begin
            if (cnt_q == DIV_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            // The first cycle with CS high is the frame-complete cycle.
            frame_done_c = (cnt_q == '0);
            if (cnt_q == GAP_LAST) begin
               state_d = CONTINUOUS ? S_CS_SETUP : S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      cs_d   = !(state_d == S_CS_SETUP || state_d == S_SHIFT || state_d == S_CS_HOLD);
      sclk_d = !(state_d == S_SHIFT && !half_d);
      busy_d = (state_d != S_IDLE);
   end

   // Word loaded into the bank at frame complete.
   always_comb begin
      for (int c = 0; c < 32; c++) begin
         load_word_c[c] = sr_q[c];
`ifdef ADC_READOUT_TEST_PATTERN_EN
         if (TEST_PAT) load_word_c[c] = SAMPLE_BITS'({frame_cnt_q, 5'(c)});
`endif
      end
   end

   assign ch_nxt_c = ch_q + 5'd1;

   // Shift registers, bank, stream handshake and overrun tracking.
   always_comb begin
      sr_d        = sr_q;
      bank_d      = bank_q;
      valid_d     = valid_q;
      ch_d        = ch_q;
      data_d      = data_q;
      ovr_d       = ovr_q;
      frame_cnt_d = frame_cnt_q;
      accept_c    = valid_q && DOUT_READY;
      bank_free_c = !valid_q || (accept_c && ch_q == 5'd31);
      if (capture_c) begin
         for (int c = 0; c < 32; c++) sr_d[c] = {sr_q[c][SAMPLE_BITS-2:0], ADC_DATA_IN[c]};
      end
      if (accept_c) begin
         ch_d   = ch_nxt_c;
         data_d = bank_q[ch_nxt_c];
         if (ch_q == 5'd31) valid_d = 1'b0;
      end
      if (CLR_OVR) ovr_d = 1'b0;
      if (frame_done_c) begin
         frame_cnt_d = frame_cnt_q + FC_W'(1);
         if (bank_free_c) begin
            bank_d  = load_word_c;
            valid_d = 1'b1;
            ch_d    = '0;
            data_d  = load_word_c[0];
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         half_q      <= 1'b0;
         bit_q       <= '0;
         sclk_q      <= 1'b1;
         cs_q        <= 1'b1;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         ch_q        <= '0;
         data_q      <= '0;
         ovr_q       <= 1'b0;
         frame_cnt_q <= '0;
         for (int c = 0; c < 32; c++) begin
            sr_q[c]   <= '0;
            bank_q[c] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         half_q      <= half_d;
         bit_q       <= bit_d;
         sclk_q      <= sclk_d;
         cs_q        <= cs_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         ch_q        <= ch_d;
         data_q      <= data_d;
         ovr_q       <= ovr_d;
         frame_cnt_q <= frame_cnt_d;
         sr_q        <= sr_d;
         bank_q      <= bank_d;
      end
   end

   assign ADC_CLK_OUT = {2{sclk_q}};
   assign ADC_CS_OUT  = {4{cs_q}};
   assign DOUT_VALID  = valid_q;
   assign DOUT_CH     = ch_q;
   assign DOUT_DATA   = data_q;
   assign BUSY        = busy_q;
   assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_adc_readout.sv
// Directed/randomized bench for adc_readout with a serial ADC model and a frame-level reference.
module tb_adc_readout;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        START = 1'b0;
   logic        CONTINUOUS = 1'b0;
   logic        CLR_OVR = 1'b0;
`ifdef ADC_READOUT_TEST_PATTERN_EN
   logic        TEST_PAT = 1'b0;
`endif
   logic [1:0]  ADC_CLK_OUT;
   logic [3:0]  ADC_CS_OUT;
   logic [31:0] ADC_DATA_IN = '0;
   logic        DOUT_VALID;
   logic        DOUT_READY = 1'b0;
   logic [4:0]  DOUT_CH;
   logic [15:0] DOUT_DATA;
   logic        BUSY;
   logic        OVERRUN;

   adc_readout dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .CONTINUOUS(CONTINUOUS), .CLR_OVR(CLR_OVR),
`ifdef ADC_READOUT_TEST_PATTERN_EN
      .TEST_PAT(TEST_PAT),
`endif
      .ADC_CLK_OUT(ADC_CLK_OUT), .ADC_CS_OUT(ADC_CS_OUT), .ADC_DATA_IN(ADC_DATA_IN),
      .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .DOUT_CH(DOUT_CH),
      .DOUT_DATA(DOUT_DATA), .BUSY(BUSY), .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Serial ADC model: a new bit (MSB first) is presented on each SCLK fall while CS is low.
   logic [15:0] adc_word [32];
   int          adc_bit = 0;
   logic        adc_prev_sclk = 1'b1;
   always @(negedge CLK) begin
      if (ADC_CS_OUT[0]) begin
         adc_bit = 0;
      end else if (adc_prev_sclk && !ADC_CLK_OUT[0] && adc_bit < 16) begin
         for (int n = 0; n < 32; n++) ADC_DATA_IN[n] = adc_word[n][15 - adc_bit];
         adc_bit++;
      end
      adc_prev_sclk = ADC_CLK_OUT[0];
   end

   // Stream monitor: collects accepted words and checks that a stalled word holds still.
   typedef struct packed { logic [4:0] ch; logic [15:0] data; } word_t;
   word_t       got [$];
   logic        p_valid = 1'b0;
   logic        p_ready = 1'b0;
   logic [4:0]  p_ch = '0;
   logic [15:0] p_data = '0;
   always @(negedge CLK) begin
      if (RST_N && p_valid && !p_ready) begin
         check("hold_valid", 32'(DOUT_VALID), 32'(1'b1));
         check("hold_ch", 32'(DOUT_CH), 32'(p_ch));
         check("hold_data", 32'(DOUT_DATA), 32'(p_data));
      end
      if (RST_N && DOUT_VALID && DOUT_READY) got.push_back({DOUT_CH, DOUT_DATA});
      p_valid = DOUT_VALID && RST_N;
      p_ready = DOUT_READY;
      p_ch    = DOUT_CH;
      p_data  = DOUT_DATA;
   end

   task automatic pulse_start();
      @(posedge CLK); #1 START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
   endtask

   task automatic count_cs(input logic lvl, output int n);
      n = 0;
      while (ADC_CS_OUT[0] === lvl && n < 2000) begin
         n++;
         @(negedge CLK);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge CLK);
      while (BUSY !== 1'b0 && n < 2000) begin
         n++;
         @(negedge CLK);
      end
      check(tag, 32'(BUSY), 32'(1'b0));
   endtask

   task automatic wait_words(input string tag, input int cnt);
      int n = 0;
      while (got.size() < cnt && n < 3000) begin
         n++;
         @(negedge CLK);
      end
      repeat (4) @(negedge CLK);
      check(tag, 32'(got.size()), 32'(cnt));
   endtask

   // Reference: a loaded frame streams as channels 0..31 carrying exactly the sampled words.
   task automatic check_frame(input string tag, input logic [15:0] exp [32]);
      for (int i = 0; i < 32 && i < got.size(); i++) begin
         check($sformatf("%s_ch%0d", tag, i), 32'(got[i].ch), 32'(i));
         check($sformatf("%s_data%0d", tag, i), 32'(got[i].data), 32'(exp[i]));
      end
   endtask

   task automatic fill_rand(output logic [15:0] w [32]);
      for (int i = 0; i < 32; i++) w[i] = 16'($urandom);
   endtask

   logic [15:0] fa [32];
   logic [15:0] fb [32];
   int          n_low, n_high, m, first_valid, falls;
   logic        prev;

   initial begin
      // Reset values
      repeat (3) @(negedge CLK);
      check("rst_sclk", 32'(ADC_CLK_OUT), 32'(2'b11));
      check("rst_cs", 32'(ADC_CS_OUT), 32'(4'hF));
      check("rst_valid", 32'(DOUT_VALID), 32'(1'b0));
      check("rst_ch", 32'(DOUT_CH), 32'(5'd0));
      check("rst_data", 32'(DOUT_DATA), 32'(16'h0));
      check("rst_busy", 32'(BUSY), 32'(1'b0));
      check("rst_ovr", 32'(OVERRUN), 32'(1'b0));
      @(posedge CLK); #1 RST_N = 1'b1;

      // Single frame, channel n = 0x1000+n
      for (int i = 0; i < 32; i++) begin
         fa[i] = 16'h1000 + 16'(i);
         adc_word[i] = fa[i];
      end
      DOUT_READY = 1'b1;
      got.delete();
      pulse_start();
      @(negedge CLK);
      check("start_cs_low", 32'(ADC_CS_OUT), 32'(4'h0));
      check("start_busy", 32'(BUSY), 32'(1'b1));
      count_cs(1'b0, n_low);
      check("cs_low_cycles", 32'(n_low), 32'd136);
      m = 0;
      first_valid = -1;
      while (BUSY && m < 1000) begin
         if (DOUT_VALID && first_valid < 0) first_valid = m;
         m++;
         @(negedge CLK);
      end
      check("busy_after_cs", 32'(m), 32'd8);
      check("valid_latency", 32'(first_valid), 32'd1);
      wait_words("single_count", 32);
      check_frame("single", fa);

      // Randomized backpressure
      fill_rand(fa);
      adc_word = fa;
      got.delete();
      pulse_start();
      repeat (400) begin
         @(posedge CLK); #1 DOUT_READY = 1'($urandom_range(0, 1));
      end
      DOUT_READY = 1'b1;
      wait_words("bp_count", 32);
      check_frame("bp", fa);

      // Overrun: second frame dropped while the bank is stalled
      fill_rand(fa);
      fill_rand(fb);
      adc_word = fa;
      DOUT_READY = 1'b0;
      CONTINUOUS = 1'b1;
      got.delete();
      pulse_start();
      @(negedge CLK);
      count_cs(1'b0, n_low);
      adc_word = fb;
      count_cs(1'b1, n_high);
      check("frame_period", 32'(n_low + n_high), 32'd144);
      count_cs(1'b0, n_low);
      @(posedge CLK); #1 CONTINUOUS = 1'b0;
      wait_idle("ovr_idle");
      check("ovr_set", 32'(OVERRUN), 32'(1'b1));
      check("ovr_valid", 32'(DOUT_VALID), 32'(1'b1));
      check("ovr_ch", 32'(DOUT_CH), 32'(5'd0));
      check("ovr_data_kept", 32'(DOUT_DATA), 32'(fa[0]));
      @(posedge CLK); #1 CLR_OVR = 1'b1;
      @(posedge CLK); #1 CLR_OVR = 1'b0;
      @(negedge CLK);
      check("ovr_clear", 32'(OVERRUN), 32'(1'b0));
      DOUT_READY = 1'b1;
      wait_words("ovr_count", 32);
      check_frame("ovr", fa);
      check("ovr_drained", 32'(DOUT_VALID), 32'(1'b0));

      // Channel 31 accepted on the frame-complete cycle of the next frame
      fill_rand(fa);
      fill_rand(fb);
      adc_word = fa;
      DOUT_READY = 1'b0;
      CONTINUOUS = 1'b1;
      got.delete();
      pulse_start();
      @(negedge CLK);
      count_cs(1'b0, n_low);
      adc_word = fb;
      repeat (113) @(posedge CLK);
      #1 DOUT_READY = 1'b1;
      repeat (32) @(posedge CLK);
      #1 DOUT_READY = 1'b0;
      CONTINUOUS = 1'b0;
      @(negedge CLK);
      check("same_ovr", 32'(OVERRUN), 32'(1'b0));
      check("same_valid", 32'(DOUT_VALID), 32'(1'b1));
      check("same_ch", 32'(DOUT_CH), 32'(5'd0));
      check("same_data", 32'(DOUT_DATA), 32'(fb[0]));
      check("same_first_count", 32'(got.size()), 32'd32);
      check_frame("same_first", fa);
      got.delete();
      DOUT_READY = 1'b1;
      wait_words("same_second_count", 32);
      check_frame("same_second", fb);
      check("same_ovr_end", 32'(OVERRUN), 32'(1'b0));

      // Reset in the middle of SHIFT with a full bank
      fill_rand(fa);
      adc_word = fa;
      DOUT_READY = 1'b0;
      pulse_start();
      wait_idle("pre_rst_idle");
      check("pre_rst_valid", 32'(DOUT_VALID), 32'(1'b1));
      fill_rand(fb);
      adc_word = fb;
      pulse_start();
      falls = 0;
      prev = 1'b1;
      m = 0;
      while (falls < 6 && m < 1000) begin
         @(negedge CLK);
         if (prev && !ADC_CLK_OUT[0]) falls++;
         prev = ADC_CLK_OUT[0];
         m++;
      end
      check("rst_reached_bit5", 32'(falls), 32'd6);
      RST_N = 1'b0;
      #1;
      check("midrst_cs", 32'(ADC_CS_OUT), 32'(4'hF));
      check("midrst_sclk", 32'(ADC_CLK_OUT), 32'(2'b11));
      check("midrst_valid", 32'(DOUT_VALID), 32'(1'b0));
      check("midrst_busy", 32'(BUSY), 32'(1'b0));
      #2 RST_N = 1'b1;
      fill_rand(fa);
      adc_word = fa;
      DOUT_READY = 1'b1;
      got.delete();
      pulse_start();
      @(negedge CLK);
      count_cs(1'b0, n_low);
      check("post_rst_cs_low", 32'(n_low), 32'd136);
      wait_words("post_rst_count", 32);
      check_frame("post_rst", fa);

`ifdef ADC_READOUT_TEST_PATTERN_EN
      // Frames 1 and 2 since reset carry {frame_counter, channel}
      TEST_PAT = 1'b1;
      for (int f = 1; f <= 2; f++) begin
         got.delete();
         pulse_start();
         wait_words($sformatf("tp%0d_count", f), 32);
         for (int i = 0; i < 32; i++) fb[i] = 16'((f << 5) | i);
         check_frame($sformatf("tp%0d", f), fb);
      end
      check("tp_ch7", 32'(got[7].data), 32'h0047);
      TEST_PAT = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
